uart_lcd_text_ctrl: RTL

//  Terminal-style HD44780 (LCD1602-class) text controller between the UART RX FIFO and the LCD pins.
//  - Pops bytes over a valid/ready handshake, runs the LCD power-up init, writes printable ASCII.
//  - Interprets control characters (CR, LF, BS, FF) and auto-wraps the cursor across a ROWS x COLS panel.
//  - Successor of the fixed 16x2 LCD path: geometry and all timings are parametrised; writes only, rw tied 0.

---
 rtl/uart_lcd_text_ctrl_if.sv | 9 +
 rtl/uart_lcd_text_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lcd_text_ctrl_if.sv
// rtl/uart_lcd_text_ctrl_if.sv - byte handshake between the UART RX FIFO and the LCD text controller
interface uart_lcd_text_ctrl_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_lcd_text_ctrl.sv
// rtl/uart_lcd_text_ctrl.sv - terminal-style HD44780 text controller fed from the UART RX FIFO
module uart_lcd_text_ctrl #(
  parameter int COLS        = 16,
  parameter int ROWS        = 2,
  parameter int POWERUP_CYC = 1_000_000,
  parameter int EN_CYC      = 25,
  parameter int CMD_CYC     = 2_500,
  parameter int CLR_CYC     = 100_000,
  localparam int RW         = (ROWS > 2) ? 2 : 1,
  localparam int CW         = $clog2(COLS + 1)
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  uart_lcd_text_ctrl_if.slave   in_if,
  output logic [7:0]            data_lcd,
  output logic                  rs,
  output logic                  rw,
  output logic                  enable,
  output logic                  busy,
  output logic [RW-1:0]         cursor_row,
  output logic [CW-1:0]         cursor_col
);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_DECODE, S_SETUP, S_PULSE, S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          op_rs_q, op_rs_d;
  logic [7:0]    op_data_q, op_data_d;
  logic          pend_q, pend_d;
  logic [7:0]    pend_data_q, pend_data_d;
  logic [2:0]    init_idx_q, init_idx_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    data_lcd_q, data_lcd_d;
  logic          rs_q, rs_d;
  logic          enable_q, enable_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic          hs;
  logic [31:0]   hold_last;
  logic [RW-1:0] nr;

  function automatic logic [7:0] set_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    logic [7:0] base;
    case (int'(r))
      1:       base = 8'h40;
      2:       base = 8'(COLS);
      3:       base = 8'(64 + COLS);
      default: base = 8'h00;
    endcase
    return 8'h80 | (base + 8'(c));
  endfunction

  function automatic logic [RW-1:0] next_row(input logic [RW-1:0] r);
    if (ROWS == 1 || int'(r) == ROWS - 1) return '0;
    return r + RW'(1);
  endfunction

  assign hs        = in_if.in_valid && in_ready_q;
  assign hold_last = (op_data_q == 8'h01 && !op_rs_q) ? 32'(CLR_CYC - 1) : 32'(CMD_CYC - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    byte_d      = byte_q;
    op_rs_d     = op_rs_q;
    op_data_d   = op_data_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    init_idx_d  = init_idx_q;
    row_d       = row_q;
    col_d       = col_q;
    nr          = next_row(row_q);

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == 32'(POWERUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_INIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_INIT: begin
        op_rs_d = 1'b0;
        case (init_idx_q)
          3'd0:    op_data_d = 8'h38;
          3'd1:    op_data_d = 8'h0C;
          3'd2:    op_data_d = 8'h01;
          default: op_data_d = 8'h06;
        endcase
        init_idx_d = init_idx_q + 3'd1;
        state_d    = S_SETUP;
      end
      S_IDLE: begin
        if (hs) begin
          byte_d  = in_if.in_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = S_IDLE;
        op_rs_d = 1'b0;
        if (byte_q >= 8'h20 && byte_q <= 8'h7E) begin
          op_rs_d   = 1'b1;
          op_data_d = byte_q;
          state_d   = S_SETUP;
          // Wrap queues a set-address so the LCD's own address counter follows the cursor.
          if (col_q + CW'(1) == CW'(COLS)) begin
            col_d       = '0;
            row_d       = nr;
            pend_d      = 1'b1;
            pend_data_d = set_addr(nr, '0);
          end else begin
            col_d = col_q + CW'(1);
          end
        end else begin
          case (byte_q)
            8'h0D: begin
              col_d     = '0;
              op_data_d = set_addr(row_q, '0);
              state_d   = S_SETUP;
            end
            8'h0A: begin
              row_d     = nr;
              col_d     = '0;
              op_data_d = set_addr(nr, '0);
              state_d   = S_SETUP;
            end
            8'h08: begin
              if (col_q != '0) begin
                col_d     = col_q - CW'(1);
                op_data_d = set_addr(row_q, col_q - CW'(1));
                state_d   = S_SETUP;
              end
            end
            8'h0C: begin
              row_d     = '0;
              col_d     = '0;
              op_data_d = 8'h01;
              state_d   = S_SETUP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == 32'(EN_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == hold_last) begin
          cnt_d = '0;
          if (init_idx_q != 3'd4) begin
            state_d = S_INIT;
          end else if (pend_q) begin
            op_rs_d   = 1'b0;
            op_data_d = pend_data_q;
            pend_d    = 1'b0;
            state_d   = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    // Pin outputs are registered one cycle behind the state they reflect.
    in_ready_d = (state_q == S_IDLE) && !hs;
    busy_d     = !in_ready_d;
    enable_d   = (state_q == S_PULSE);
    data_lcd_d = (state_q == S_SETUP) ? op_data_q : data_lcd_q;
    rs_d       = (state_q == S_SETUP) ? op_rs_q : rs_q;
  end

  always_ff @(posedge clk_50MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      byte_q      <= '0;
      op_rs_q     <= 1'b0;
      op_data_q   <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      init_idx_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      data_lcd_q  <= '0;
      rs_q        <= 1'b0;
      enable_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      byte_q      <= byte_d;
      op_rs_q     <= op_rs_d;
      op_data_q   <= op_data_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      init_idx_q  <= init_idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      data_lcd_q  <= data_lcd_d;
      rs_q        <= rs_d;
      enable_q    <= enable_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign data_lcd       = data_lcd_q;
  assign rs             = rs_q;
  assign rw             = 1'b0;
  assign enable         = enable_q;
  assign busy           = busy_q;
  assign cursor_row     = row_q;
  assign cursor_col     = col_q;

endmodule
